chip8_mem_responder: RTL and testbench
======================================

// Module: chip8_mem_responder
// PURPOSE
//  Memory-side responder for the chip8_cpu memory port: 4 KiB x 8 synchronous RAM.
//  Answers CPU mem_read/mem_write with the fixed 1-cycle read latency the CPU expects.
//  After reset it preloads the 16-glyph hex font, then accepts a program byte stream
//  at PROG_BASE, then releases the CPU. Sits between chip8_cpu and the host loader.
// PARAMETERS
//  ADDR_W     12      address width; depth = 2**ADDR_W bytes
//  DATA_W     8       data width
//  FONT_BASE  12'h050 first address of the 80-byte font block
//  PROG_BASE  12'h200 first address written by the program loader
//  LOAD_EN    1       1: LOAD phase after font init; 0: go straight to SERVE
// PORTS
//  clk           in   1       single clock, all logic on posedge
//  reset         in   1       asynchronous, active-low
//  mem_read      in   1       CPU read request, sampled at posedge
//  mem_write     in   1       CPU write request, sampled at posedge
//  mem_addr_out  in   ADDR_W  CPU address
//  mem_data_out  in   DATA_W  CPU write data
//  mem_data_in   out  DATA_W  read data to CPU (registered)
//  cpu_hold      out  1       1 while not in SERVE; CPU must stay in reset/stall
//  load_valid    in   1       host byte valid
//  load_data     in   DATA_W  host program byte
//  load_last     in   1       marks final byte of program (qualified by load_valid)
//  load_ready    out  1       1 only in LOAD state
//  load_ovf      out  1       sticky: a load byte was dropped past top of memory
// BEHAVIOUR
//  Reset (reset==0, async): state=FONT_INIT, font_idx=0, load_ptr=PROG_BASE,
//   mem_data_in=0, cpu_hold=1, load_ready=0, load_ovf=0. RAM contents not cleared.
//  FONT_INIT: one byte per cycle, RAM[FONT_BASE+i]=FONT[i], i=0..79 (standard
//   CHIP-8 hex font, glyph 0 = F0 90 90 90 F0, glyph 1 = 20 60 20 20 70, ...).
//   After i=79 write: -> LOAD if LOAD_EN else SERVE. Exactly 80 cycles.
//  LOAD: load_ready=1. On posedge with load_valid: if load_ptr<=max addr write
//   RAM[load_ptr]=load_data, load_ptr++ ; else drop byte, set load_ovf.
//   load_ptr saturates at 2**ADDR_W (no wrap to 0; font never overwritten by wrap).
//   load_valid&&load_last -> SERVE same edge (last byte still written).
//  SERVE: cpu_hold=0, load_ready=0, load_valid ignored.
//   mem_read at edge N -> mem_data_in = RAM[mem_addr_out] valid after edge N+1
//   (registered 1-cycle latency). mem_data_in holds last value when no read.
//   mem_write at edge N -> RAM[mem_addr_out]=mem_data_out at edge N.
//   read+write same cycle, same address: read returns OLD data (read-before-write).
//  Outside SERVE, mem_read/mem_write are ignored; mem_data_in holds.
//  Reset asserted mid-FONT_INIT/LOAD/SERVE: immediate return to reset values;
//   sequence restarts from font byte 0; partially loaded program bytes remain in RAM
//   but load_ptr restarts at PROG_BASE.
//  No other states; SERVE is terminal until reset.
// TESTING
//  1 Reset release, LOAD_EN=1: load_ready rises exactly 80 clk after reset deasserts;
//    cpu_hold=1 throughout.
//  2 Load bytes 00 E0 12 00 (last on 4th): RAM[200..203]=00,E0,12,00; cpu_hold falls
//    the cycle after last; load_ready=0.
//  3 SERVE read 0x050 -> mem_data_in=F0 one cycle later; read 0x055 -> 20;
//    read 0x201 -> E0.
//  4 Same-cycle read+write 0x300 (old 00, write AB): mem_data_in=00, next read -> AB.
//  5 Load 0xE01 bytes from PROG_BASE: bytes past 0xFFF dropped, load_ovf=1,
//    RAM[0x050]=F0 unchanged.
//  6 Assert reset during LOAD after 2 bytes: outputs return to reset values
//    immediately (async); after release, 80-cycle font init repeats, load_ptr=0x200.

Source files
------------

// File: rtl/chip8_mem_responder.sv
// rtl/chip8_mem_responder.sv - CHIP-8 4 KiB RAM responder: font preload, program load, CPU service
module chip8_mem_responder #(
    parameter int              ADDR_W    = 12,
    parameter int              DATA_W    = 8,
    parameter logic [ADDR_W-1:0] FONT_BASE = ADDR_W'(12'h050),
    parameter logic [ADDR_W-1:0] PROG_BASE = ADDR_W'(12'h200),
    parameter bit              LOAD_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              cpu_hold,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_ovf
);

    localparam int DEPTH    = 2**ADDR_W;
    localparam int FONT_LEN = 80;

    localparam logic [8*FONT_LEN-1:0] FONT = {
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    typedef enum logic [1:0] {FONT_INIT, LOAD, SERVE} state_t;
    localparam state_t AFTER_FONT = LOAD_EN ? LOAD : SERVE;

    state_t            state;
    logic [6:0]        font_idx;
    logic [ADDR_W:0]   load_ptr;
    logic [DATA_W-1:0] ram [DEPTH];

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] font_byte;
    logic              font_done;
    logic              ptr_full;

    // Byte 0 of the font sits in the most significant byte of the constant.
    assign font_byte = DATA_W'(FONT[(FONT_LEN - 1 - int'(font_idx)) * 8 +: 8]);
    assign font_done = (font_idx == 7'(FONT_LEN - 1));
    assign ptr_full  = load_ptr[ADDR_W];

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            FONT_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = FONT_BASE + ADDR_W'(font_idx);
                ram_wdata = font_byte;
            end
            LOAD: begin
                ram_we    = load_valid && !ptr_full;
                ram_addr  = load_ptr[ADDR_W-1:0];
                ram_wdata = load_data;
            end
            SERVE: begin
                ram_we    = mem_write;
                ram_addr  = mem_addr_out;
                ram_wdata = mem_data_out;
            end
            default: ;
        endcase
        if (!reset) ram_we = 1'b0;
    end

    // Storage is never reset; a read in the same cycle sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FONT_INIT;
            font_idx    <= '0;
            load_ptr    <= {1'b0, PROG_BASE};
            mem_data_in <= '0;
            cpu_hold    <= 1'b1;
            load_ready  <= 1'b0;
            load_ovf    <= 1'b0;
        end else begin
            case (state)
                FONT_INIT: begin
                    font_idx <= font_idx + 7'd1;
                    if (font_done) begin
                        state      <= AFTER_FONT;
                        load_ready <= LOAD_EN;
                        cpu_hold   <= LOAD_EN;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        // Pointer parks at 2**ADDR_W so late bytes never wrap onto the font.
                        if (ptr_full) load_ovf <= 1'b1;
                        else          load_ptr <= load_ptr + 1'b1;
                        if (load_last) begin
                            state      <= SERVE;
                            load_ready <= 1'b0;
                            cpu_hold   <= 1'b0;
                        end
                    end
                end
                SERVE: begin
                    if (mem_read) mem_data_in <= ram[mem_addr_out];
                end
                default: state <= FONT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_mem_responder.sv
// tb/tb_chip8_mem_responder.sv - scoreboard bench for chip8_mem_responder
module tb_chip8_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [11:0] mem_addr_out = '0;
    logic [7:0]  mem_data_out = '0;
    logic [7:0]  mem_data_in;
    logic        cpu_hold;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        load_ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    logic [7:0] font_exp [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    chip8_mem_responder dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .cpu_hold     (cpu_hold),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .load_ovf     (load_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [11:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        mem_read     = 1'b1;
        mem_addr_out = a;
        tick();
        mem_read = 1'b0;
        tick();
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
        mem_write    = 1'b1;
        mem_addr_out = a;
        mem_data_out = d;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Releases reset just after an edge and counts edges until load_ready rises (0 = timeout).
    task automatic wait_font(output int cyc, output bit hold_ok);
        cyc     = 0;
        hold_ok = 1'b1;
        tick();
        reset = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (cpu_hold !== 1'b1) hold_ok = 1'b0;
            if (load_ready === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        n_vec++; if (mem_data_in !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", mem_data_in); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL reset_hold: got %b expected 1", cpu_hold); end
        n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", load_ready); end
        n_vec++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", load_ovf); end
    endtask

    task automatic test_font_init;
        int cyc;
        bit hold_ok;
        wait_font(cyc, hold_ok);
        n_vec++; if (cyc != 80) begin n_err++; $display("FAIL font_init_cycles: got %0d expected 80", cyc); end
        n_vec++; if (!hold_ok) begin n_err++; $display("FAIL font_init_hold: got cpu_hold low expected 1"); end
    endtask

    task automatic test_load;
        // CPU accesses during LOAD must be ignored: read leaves data at 0, write must not clobber font
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        mem_addr_out = 12'h050;
        mem_data_out = 8'h00;
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        n_vec++; if (mem_data_in !== 8'h00) begin n_err++; $display("FAIL load_read_ignored: got %h expected 00", mem_data_in); end
        load_byte(8'h00, 1'b0);
        load_byte(8'hE0, 1'b0);
        load_byte(8'h12, 1'b0);
        n_vec++; if (load_ready !== 1'b1 || cpu_hold !== 1'b1) begin n_err++; $display("FAIL load_mid: got ready=%b hold=%b expected 1 1", load_ready, cpu_hold); end
        load_byte(8'h00, 1'b1);
        n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL load_hold_fall: got %b expected 0", cpu_hold); end
        n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_fall: got %b expected 0", load_ready); end
    endtask

    task automatic test_serve_read;
        logic [11:0] addrs [7] = '{12'h050, 12'h055, 12'h201, 12'h200, 12'h202, 12'h203, 12'h09F};
        logic [7:0]  exps  [7] = '{8'hF0, 8'h20, 8'hE0, 8'h00, 8'h12, 8'h00, 8'h80};
        logic [7:0] e;
        for (int i = 0; i < 7; i++) begin
            issue_read(addrs[i], exps[i]);
            e = exp_q.pop_front();
            n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL serve_read[%03h]: got %h expected %h", addrs[i], mem_data_in, e); end
        end
        for (int i = 0; i < 80; i++) begin
            issue_read(12'h050 + 12'(i), font_exp[i]);
            e = exp_q.pop_front();
            n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL font_byte[%0d]: got %h expected %h", i, mem_data_in, e); end
        end
        repeat (3) tick();
        n_vec++; if (mem_data_in !== 8'h80) begin n_err++; $display("FAIL read_hold: got %h expected 80", mem_data_in); end
        // load stream must be ignored once serving
        cpu_write(12'h204, 8'h99);
        load_byte(8'h77, 1'b0);
        issue_read(12'h204, 8'h99);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL serve_load_ignored: got %h expected %h", mem_data_in, e); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        cpu_write(12'h300, 8'h00);
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        mem_addr_out = 12'h300;
        mem_data_out = 8'hAB;
        exp_q.push_back(8'h00);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL rw_old_data: got %h expected %h", mem_data_in, e); end
        issue_read(12'h300, 8'hAB);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL rw_new_data: got %h expected %h", mem_data_in, e); end
    endtask

    task automatic test_overflow;
        int cyc;
        bit hold_ok;
        logic [7:0] e;
        reset = 1'b0;
        tick();
        wait_font(cyc, hold_ok);
        n_vec++; if (cyc != 80) begin n_err++; $display("FAIL ovf_font_cycles: got %0d expected 80", cyc); end
        for (int i = 0; i < 'hE01; i++) begin
            load_byte(8'(i) ^ 8'h5A, i == 'hE00);
            if (i == 'hDFF) begin
                n_vec++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_top: got %b expected 0", load_ovf); end
            end
        end
        n_vec++; if (load_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", load_ovf); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL ovf_serve: got %b expected 0", cpu_hold); end
        issue_read(12'h200, 8'h5A);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL ovf_first: got %h expected %h", mem_data_in, e); end
        issue_read(12'hFFF, 8'hFF ^ 8'h5A);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL ovf_top: got %h expected %h", mem_data_in, e); end
        issue_read(12'h050, 8'hF0);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL ovf_font_intact: got %h expected %h", mem_data_in, e); end
        issue_read(12'h09F, 8'h80);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL ovf_font_end: got %h expected %h", mem_data_in, e); end
    endtask

    task automatic test_reset_mid_load;
        int cyc;
        bit hold_ok;
        logic [7:0] e;
        // async reset out of SERVE, between edges
        #2 reset = 1'b0;
        #1;
        n_vec++; if (mem_data_in !== 8'h00) begin n_err++; $display("FAIL async_data: got %h expected 00", mem_data_in); end
        n_vec++; if (load_ovf !== 1'b0) begin n_err++; $display("FAIL async_ovf: got %b expected 0", load_ovf); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL async_hold: got %b expected 1", cpu_hold); end
        wait_font(cyc, hold_ok);
        n_vec++; if (cyc != 80) begin n_err++; $display("FAIL mid_font_cycles: got %0d expected 80", cyc); end
        load_byte(8'h11, 1'b0);
        load_byte(8'h22, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_vec++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b expected 0", load_ready); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL mid_hold: got %b expected 1", cpu_hold); end
        wait_font(cyc, hold_ok);
        n_vec++; if (cyc != 80) begin n_err++; $display("FAIL refont_cycles: got %0d expected 80", cyc); end
        n_vec++; if (!hold_ok) begin n_err++; $display("FAIL refont_hold: got cpu_hold low expected 1"); end
        load_byte(8'h33, 1'b1);
        issue_read(12'h200, 8'h33);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL reload_ptr: got %h expected %h", mem_data_in, e); end
        issue_read(12'h201, 8'h22);
        e = exp_q.pop_front();
        n_vec++; if (mem_data_in !== e) begin n_err++; $display("FAIL partial_kept: got %h expected %h", mem_data_in, e); end
    endtask

    initial begin
        test_reset();
        test_font_init();
        test_load();
        test_serve_read();
        test_back_to_back();
        test_overflow();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
